// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// signed-magnitude input, sticky overflow flag and leading-zero blanking mask.
module binary_bcd_seq #(
  parameter int DATA_W = 36,
  parameter int DIGITS = 11
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DATA_W-1:0]     data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank,
  output logic [1:0]            fsm_state
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [DATA_W-1:0] bin_q, bin_n;
  logic [BW-1:0]   scr_q, scr_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            neg_q, neg_n;
  logic            ovf_q, ovf_n;
  logic [BW-1:0]   adj;
  logic [DIGITS-1:0] blank_c;
  logic            zero_above;

  // Handshake: start is accepted only in IDLE (busy=0); busy stays high while
  // bits are shifted; done pulses for one cycle when bcd/neg/ovf/blank update.
  assign busy      = (state == SHIFT);
  assign fsm_state = state;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Blanking looks only at the final scratch, scanning from the top digit down.
  always_comb begin
    blank_c    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (scr_q[4*i +: 4] == 4'd0);
      blank_c[i] = zero_above;
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin_q;
    scr_n   = scr_q;
    cnt_n   = cnt_q;
    neg_n   = neg_q;
    ovf_n   = ovf_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (signed_mode && data[DATA_W-1]) begin
            bin_n = ~data + DATA_W'(1);
            neg_n = 1'b1;
          end else begin
            bin_n = data;
            neg_n = 1'b0;
          end
          scr_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = CW'(DATA_W);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        scr_n = {adj[BW-2:0], bin_q[DATA_W-1]};
        bin_n = {bin_q[DATA_W-2:0], 1'b0};
        if (adj[BW-1]) ovf_n = 1'b1;
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_n = FINISH;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      bin_q <= bin_n;
      scr_q <= scr_n;
      cnt_q <= cnt_n;
      neg_q <= neg_n;
      ovf_q <= ovf_n;
    end
  end

  // Result registers change only in FINISH, so no partial value is ever visible.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      done  <= 1'b0;
      bcd   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) begin
        bcd   <= scr_q;
        neg   <= neg_q;
        ovf   <= ovf_q;
        blank <= blank_c;
      end
    end
  end

endmodule
